alu_nibble_sequencer: RTL and testbench

ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

---
 rtl/alu_nibble_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// Sequences a 16-bit ADD/SUB/AND/XOR through an external 4-bit ALU slice,
// one nibble per clock, least-significant nibble first.
module alu_nibble_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        cout,
   output logic        zero,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [3:0]  alu_s,
   output logic        alu_m_n,
   output logic        alu_ci_n,
   input  logic [3:0]  alu_f,
   input  logic        alu_co_n
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   state_t      r_state;
   state_t      w_next_state;
   logic [1:0]  r_idx;
   logic [1:0]  r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_acc;
   logic        r_carry;
   logic [15:0] r_result;
   logic        r_cout;
   logic        r_zero;
   logic        w_arith;
   logic        w_carry_next;
   logic [15:0] w_final;

   assign w_arith      = (r_op == OP_ADD) || (r_op == OP_SUB);
   assign w_carry_next = w_arith ? ~alu_co_n : 1'b0;
   // The last nibble comes straight from the slice so the final result lands in the same edge.
   assign w_final      = {alu_f, r_acc[11:0]};

   assign busy   = (r_state == ST_EXEC);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign cout   = r_cout;
   assign zero   = r_zero;

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_EXEC;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (r_idx == 2'd3) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_EXEC;
            end
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Slice drive: operand nibbles and function select come only from held registers
   always_comb begin
      alu_a    = 4'h0;
      alu_b    = 4'h0;
      alu_s    = 4'b0000;
      alu_m_n  = 1'b1;
      alu_ci_n = 1'b1;
      if (r_state == ST_EXEC) begin
         alu_a = r_a[{r_idx, 2'b00} +: 4];
         alu_b = r_b[{r_idx, 2'b00} +: 4];
         case (r_op)
            OP_ADD: begin
               alu_s   = 4'b1001;
               alu_m_n = 1'b0;
            end
            OP_SUB: begin
               alu_s   = 4'b0110;
               alu_m_n = 1'b0;
            end
            OP_AND: begin
               alu_s   = 4'b1011;
               alu_m_n = 1'b1;
            end
            OP_XOR: begin
               alu_s   = 4'b0110;
               alu_m_n = 1'b1;
            end
            default: begin
               alu_s   = 4'b0000;
               alu_m_n = 1'b1;
            end
         endcase
         if (!w_arith) begin
            alu_ci_n = 1'b1;
         end else if (r_idx == 2'd0) begin
            // SUB needs a carry of one into the LSB nibble to form A + ~B + 1
            alu_ci_n = (r_op == OP_SUB) ? 1'b0 : 1'b1;
         end else begin
            alu_ci_n = ~r_carry;
         end
      end else begin
         alu_ci_n = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand capture, nibble accumulation and result/flag update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= 2'd0;
         r_op     <= 2'b00;
         r_a      <= 16'h0000;
         r_b      <= 16'h0000;
         r_acc    <= 16'h0000;
         r_carry  <= 1'b0;
         r_result <= 16'h0000;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a_in;
                  r_b     <= b_in;
                  r_op    <= op;
                  r_idx   <= 2'd0;
                  r_carry <= 1'b0;
               end
            end
            ST_EXEC: begin
               r_acc[{r_idx, 2'b00} +: 4] <= alu_f;
               r_carry                    <= w_carry_next;
               r_idx                      <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  r_result <= w_final;
                  r_cout   <= w_carry_next;
                  r_zero   <= (w_final == 16'h0000);
               end
            end
            default: begin
               r_idx <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized and directed self-checking bench for alu_nibble_sequencer with a
// behavioural 4-bit slice attached and a whole-word arithmetic reference model.
module tb_alu_nibble_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] a_in = 16'h0000;
   logic [15:0] b_in = 16'h0000;
   logic        busy, done, cout, zero;
   logic [15:0] result;
   logic [3:0]  alu_a, alu_b, alu_s, alu_f;
   logic        alu_m_n, alu_ci_n, alu_co_n;

   int n_pass = 0;
   int n_total = 0;

   alu_nibble_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m_n(alu_m_n),
      .alu_ci_n(alu_ci_n), .alu_f(alu_f), .alu_co_n(alu_co_n)
   );

   always #5 clk = ~clk;

   // 4-bit ALU slice: active-high data, active-low carries
   always_comb begin
      logic [4:0] s;
      s        = 5'd0;
      alu_f    = 4'h0;
      alu_co_n = 1'b1;
      case ({alu_m_n, alu_s})
         5'b0_1001: begin
            s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, ~alu_ci_n};
            alu_f = s[3:0]; alu_co_n = ~s[4];
         end
         5'b0_0110: begin
            s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, ~alu_ci_n};
            alu_f = s[3:0]; alu_co_n = ~s[4];
         end
         5'b1_1011: alu_f = alu_a & alu_b;
         5'b1_0110: alu_f = alu_a ^ alu_b;
         default:   alu_f = 4'h0;
      endcase
   end

   // Whole-word reference: {cout, result}
   function automatic logic [16:0] ref_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      case (o)
         2'b00:   ref_op = {1'b0, a} + {1'b0, b};
         2'b01:   ref_op = {(a >= b), 16'(a - b)};
         2'b10:   ref_op = {1'b0, a & b};
         default: ref_op = {1'b0, a ^ b};
      endcase
   endfunction

   // Expected slice drive for nibble k: {alu_a, alu_b, alu_s, alu_m_n, alu_ci_n}
   function automatic logic [13:0] ref_drive(input logic [1:0] o, input logic [15:0] a,
                                             input logic [15:0] b, input int k);
      logic [15:0] m;
      logic [16:0] low_sum;
      logic        carry_in;
      logic [4:0]  fsel;
      m        = 16'((32'd1 << (4 * k)) - 32'd1);
      low_sum  = {1'b0, a & m} + {1'b0, b & m};
      carry_in = (o == 2'b00) ? low_sum[4 * k] : ((a & m) >= (b & m));
      case (o)
         2'b00:   fsel = 5'b1001_0;
         2'b01:   fsel = 5'b0110_0;
         2'b10:   fsel = 5'b1011_1;
         default: fsel = 5'b0110_1;
      endcase
      ref_drive = {a[4 * k +: 4], b[4 * k +: 4], fsel, (o[1] ? 1'b1 : ~carry_in)};
   endfunction

   task automatic test_operation(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input bit hold, input string name);
      logic [16:0] exp;
      logic [13:0] drv;
      exp = ref_op(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      a_in = 16'($urandom); b_in = 16'($urandom); op = 2'($urandom);
      for (int k = 0; k < 4; k++) begin
         drv = ref_drive(o, a, b, k);
         n_total++;
         if (busy !== 1'b1 || done !== 1'b0) $display("FAIL %s busy/done nib%0d: got %b/%b want 1/0", name, k, busy, done);
         else n_pass++;
         n_total++;
         if ({alu_a, alu_b, alu_s, alu_m_n, alu_ci_n} !== drv)
            $display("FAIL %s drive nib%0d: got %h want %h", name, k, {alu_a, alu_b, alu_s, alu_m_n, alu_ci_n}, drv);
         else n_pass++;
         @(posedge clk); #1;
      end
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== exp[15:0] || cout !== exp[16] || zero !== (exp[15:0] == 16'h0))
         $display("FAIL %s result: got done=%b busy=%b res=%h c=%b z=%b want 1 0 %h %b %b",
                  name, done, busy, result, cout, zero, exp[15:0], exp[16], (exp[15:0] == 16'h0));
      else n_pass++;
      @(posedge clk); #1;
      start = 1'b0;
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp[15:0] || cout !== exp[16])
         $display("FAIL %s hold: got done=%b busy=%b res=%h c=%b want 0 0 %h %b", name, done, busy, result, cout, exp[15:0], exp[16]);
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({busy, done, cout, zero, result, alu_a, alu_b, alu_s, alu_m_n, alu_ci_n} !== {4'b0000, 16'h0000, 12'h000, 2'b11})
         $display("FAIL reset_state: got %b%b%b%b res=%h a=%h b=%h s=%h m=%b ci=%b want all idle",
                  busy, done, cout, zero, result, alu_a, alu_b, alu_s, alu_m_n, alu_ci_n);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1; op = 2'b00; a_in = 16'h0003; b_in = 16'h0004;
      @(posedge clk); #1;
      start = 1'b0;
      n_total++;
      if (busy !== 1'b1) $display("FAIL first_edge_accept: got busy=%b want 1", busy);
      else n_pass++;
      repeat (4) @(posedge clk);
      #1;
      n_total++;
      if (done !== 1'b1 || result !== 16'h0007) $display("FAIL first_op: got done=%b res=%h want 1 0007", done, result);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      test_operation(2'b00, 16'h0FFF, 16'h0001, 1'b0, "add_0fff");
      test_operation(2'b00, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
      test_operation(2'b01, 16'h1234, 16'h1234, 1'b0, "sub_equal");
      test_operation(2'b01, 16'h0001, 16'h0002, 1'b0, "sub_borrow");
      test_operation(2'b10, 16'hF0F0, 16'hFF00, 1'b0, "and");
      test_operation(2'b11, 16'hAAAA, 16'hFFFF, 1'b0, "xor");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         test_operation(2'($urandom), 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      start = 1'b1; op = 2'b00; a_in = 16'h0001; b_in = 16'h0001;
      @(posedge clk); #1;                      // edge N
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b01; a_in = 16'h9999; b_in = 16'h1111;
      @(posedge clk); #1;                      // edge N+2
      start = 1'b0;
      @(posedge clk); #1;                      // edge N+3
      n_total++;
      if (busy !== 1'b1) $display("FAIL b2b_busy_n3: got %b want 1", busy);
      else n_pass++;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;                      // edge N+4
      n_total++;
      if (busy !== 1'b0 || done !== 1'b1 || result !== 16'h0002)
         $display("FAIL b2b_n4: got busy=%b done=%b res=%h want 0 1 0002", busy, done, result);
      else n_pass++;
      @(posedge clk); #1;                      // edge N+5, start ignored in DONE
      start = 1'b0;
      @(posedge clk); #1;                      // edge N+6
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0002)
         $display("FAIL b2b_ignored: got busy=%b done=%b res=%h want 0 0 0002", busy, done, result);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int done_seen;
      done_seen = 0;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a_in = 16'h1111; b_in = 16'h2222;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;                                      // between N+2 and N+3
      rst_n = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || {alu_a, alu_b, alu_s, alu_m_n, alu_ci_n} !== 14'h0003)
         $display("FAIL abort_immediate: got busy=%b done=%b res=%h drv=%h want 0 0 0000 0003",
                  busy, done, result, {alu_a, alu_b, alu_s, alu_m_n, alu_ci_n});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      end
      n_total++;
      if (done_seen != 0 || result !== 16'h0000)
         $display("FAIL abort_quiet: got activity=%0d res=%h want 0 0000", done_seen, result);
      else n_pass++;
      test_operation(2'b00, 16'h1111, 16'h2222, 1'b0, "after_abort");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
